uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Shares the single UART transmitter between the debug TAP's two byte producers: the read serializer (data bytes) and the address-change/notification path (command bytes). Command bytes are queued in a small FIFO and have priority, with a starvation bound that guarantees data progress. The block owns the TX write handshake and tells the UART whether each byte is framed as a command. It sits between the TAP's serializer/read arbiter and the UART TX, replacing direct drive of the UART write and command ports.

## Interface
Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of two, ≥2
- STARVE_LIMIT, 4, max consecutive command grants while a data byte waits; ≥1

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  reset, asynchronous, active-high
- DATA_WRITE_I  in  1  data byte request
- DATA_I  in  8  data byte
- DATA_READY_O  out  1  data holding register empty
- CMD_SEND_I  in  1  command byte request
- CMD_I  in  8  command byte
- CMD_READY_O  out  1  command FIFO not full
- CMD_LEVEL_O  out  $clog2(CMD_DEPTH)+1  command FIFO occupancy
- CMD_OVERFLOW_O  out  1  sticky: command pushed while full
- CLR_OVERFLOW_I  in  1  clears CMD_OVERFLOW_O
- TX_READY_I  in  1  UART can accept a byte
- TX_WRITE_O  out  1  byte valid to UART
- TX_DATA_O  out  8  byte to UART
- TX_IS_CMD_O  out  1  byte is a command (UART applies command framing)
- BUSY_O  out  1  FSM not in IDLE

## Operation
- Data side: one-entry holding register. Accept when DATA_WRITE_I && DATA_READY_O; DATA_READY_O = holding empty (combinational). Request while not ready is ignored, no flag.
- Command side: FIFO, CMD_DEPTH entries, wrap-around pointers, one extra count bit. Push when CMD_SEND_I && CMD_READY_O. CMD_SEND_I while full: byte dropped, CMD_OVERFLOW_O set. Push while full is dropped even if a pop occurs the same cycle (CMD_READY_O = !full from current count). Simultaneous push and pop when not full: level unchanged.
- CLR_OVERFLOW_I clears the overflow flag; a set in the same cycle wins.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if any source pending, grant one, load TX_DATA_O/TX_IS_CMD_O, pop the FIFO or empty the holding register, assert TX_WRITE_O, go to SEND. Otherwise stay.
  - SEND: hold TX_WRITE_O, TX_DATA_O, TX_IS_CMD_O stable. When TX_WRITE_O && TX_READY_I at a clock edge, the byte is transferred: deassert TX_WRITE_O and go to GAP.
  - GAP: one cycle with TX_WRITE_O low, so the UART can drop TX_READY_I. Then go to IDLE.
- Arbitration in IDLE:
  - Command wins unless streak == STARVE_LIMIT and a data byte is pending; then data wins.
  - streak: 0..STARVE_LIMIT, saturating. Increments on each command grant while data is pending. Clears on data grant, and whenever data holding is empty in IDLE.
- TX_IS_CMD_O = 1 for FIFO bytes, 0 for data bytes.

## Timing
- Reset values: TX_WRITE_O 0, TX_DATA_O 0x00, TX_IS_CMD_O 0, DATA_READY_O 1, CMD_READY_O 1, CMD_LEVEL_O 0, CMD_OVERFLOW_O 0, BUSY_O 0. FSM in IDLE, streak 0, pointers 0.
- Latency: request sampled at edge E0 (stored); IDLE grants at E1; TX_WRITE_O high after E1. Idle-to-TX is 2 cycles.
- Minimum byte period when TX_READY_I is held high: 3 cycles (SEND accept, GAP, IDLE grant).
- TX_READY_I low in SEND: wait indefinitely with outputs stable. No timeout, no preemption by later command bytes.
- A source freed at a grant edge can accept a new request in the next cycle.
- Asynchronous reset mid-transfer: all state cleared immediately, TX_WRITE_O drops; in-flight and queued bytes are lost.

## Test plan
- Single command 0x15, TX_READY_I=1 → TX_WRITE_O rises 2 cycles after CMD_SEND_I with TX_DATA_O=0x15, TX_IS_CMD_O=1. Asserted 1 cycle, BUSY_O back to 0 after GAP.
- Data byte 0xA5 queued with 6 commands pending, STARVE_LIMIT=4 → TX order cmd,cmd,cmd,cmd,0xA5(IS_CMD=0),cmd,cmd.
- Push 5 commands into CMD_DEPTH=4 while TX_READY_I=0 → CMD_LEVEL_O=4, CMD_READY_O=0, CMD_OVERFLOW_O=1. The 5th byte is never transmitted. CLR_OVERFLOW_I clears the flag.
- TX_READY_I held low for 10 cycles in SEND → TX_WRITE_O/TX_DATA_O stable throughout. Transfer completes at the first edge with TX_READY_I=1.
- Push and pop in the same cycle at level 2 → level stays 2. Push while full with a same-cycle pop → byte dropped, overflow set.
- RST_I asserted mid-SEND with 3 commands queued → outputs go to reset values without a clock edge. Nothing is transmitted after release until new requests arrive.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Purpose : arbitrates one UART transmitter between a queued command source and a one-entry data source.
// Latency : a request stored at edge E0 is granted at E1; TX_WRITE_O is high after E1 (idle-to-TX 2 cycles).
// Backpres: TX_WRITE_O/TX_DATA_O hold in SEND until TX_READY_I; DATA_READY_O / CMD_READY_O stall producers.
//
// Ports:
//   CLK_I, RST_I                     clock, asynchronous active-high reset
//   DATA_WRITE_I, DATA_I, DATA_READY_O   data byte request into the one-entry holding register
//   CMD_SEND_I, CMD_I, CMD_READY_O       command byte request into the command FIFO
//   CMD_LEVEL_O, CMD_OVERFLOW_O, CLR_OVERFLOW_I   FIFO occupancy and sticky drop flag with clear
//   TX_READY_I, TX_WRITE_O, TX_DATA_O, TX_IS_CMD_O   write handshake toward the UART
//   BUSY_O                           scheduler is not idle
module uart_tx_scheduler #(
    parameter int CMD_DEPTH    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    input  logic                         DATA_WRITE_I,
    input  logic [7:0]                   DATA_I,
    output logic                         DATA_READY_O,
    input  logic                         CMD_SEND_I,
    input  logic [7:0]                   CMD_I,
    output logic                         CMD_READY_O,
    output logic [$clog2(CMD_DEPTH):0]   CMD_LEVEL_O,
    output logic                         CMD_OVERFLOW_O,
    input  logic                         CLR_OVERFLOW_I,
    input  logic                         TX_READY_I,
    output logic                         TX_WRITE_O,
    output logic [7:0]                   TX_DATA_O,
    output logic                         TX_IS_CMD_O,
    output logic                         BUSY_O
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [LW-1:0] FULL_LVL   = LW'(CMD_DEPTH);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t          state, state_nxt;

    logic            data_full;
    logic [7:0]      data_hold;
    logic [7:0]      cmd_mem [CMD_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   cmd_cnt;
    logic [SW-1:0]   streak;
    logic            overflow;
    logic            tx_write;
    logic [7:0]      tx_data;
    logic            tx_is_cmd;

    logic            cmd_full, cmd_push, data_push;
    logic            grant_cmd, grant_data, tx_accept;

    // Readiness comes from the current count only, so a push into a full
    // FIFO is dropped even if the same edge pops an entry.
    assign cmd_full  = (cmd_cnt == FULL_LVL);
    assign cmd_push  = CMD_SEND_I && !cmd_full;
    assign data_push = DATA_WRITE_I && !data_full;

    // ---------------- FSM ----------------
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_cmd  = 1'b0;
        grant_data = 1'b0;
        tx_accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Commands win unless the streak limit has been reached while data waits.
                if (data_full && (cmd_cnt == '0 || streak == STREAK_MAX))
                    grant_data = 1'b1;
                else if (cmd_cnt != '0)
                    grant_cmd = 1'b1;
                if (grant_data || grant_cmd)
                    state_nxt = ST_SEND;
            end
            ST_SEND: begin
                // TX_WRITE_O is always high in SEND, so TX_READY_I alone completes the transfer.
                if (TX_READY_I) begin
                    tx_accept = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- data holding register ----------------
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            data_full <= 1'b0;
            data_hold <= 8'h00;
        end else if (grant_data) begin
            data_full <= 1'b0;
        end else if (data_push) begin
            data_full <= 1'b1;
            data_hold <= DATA_I;
        end
    end

    // ---------------- command FIFO ----------------
    always_ff @(posedge CLK_I) begin
        if (cmd_push) cmd_mem[wr_ptr] <= CMD_I;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push)  wr_ptr <= wr_ptr + 1'b1;
            if (grant_cmd) rd_ptr <= rd_ptr + 1'b1;
            case ({cmd_push, grant_cmd})
                2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
                2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
                default: cmd_cnt <= cmd_cnt;
            endcase
        end
    end

    // Sticky drop flag; a new drop in the same cycle as a clear keeps it set.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)                      overflow <= 1'b0;
        else if (CMD_SEND_I && cmd_full) overflow <= 1'b1;
        else if (CLR_OVERFLOW_I)        overflow <= 1'b0;
    end

    // ---------------- starvation streak ----------------
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            streak <= '0;
        end else if (state == ST_IDLE) begin
            if (grant_data || !data_full)
                streak <= '0;
            else if (grant_cmd && streak != STREAK_MAX)
                streak <= streak + 1'b1;
        end
    end

    // ---------------- UART write port ----------------
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            tx_write  <= 1'b0;
            tx_data   <= 8'h00;
            tx_is_cmd <= 1'b0;
        end else if (grant_cmd) begin
            tx_write  <= 1'b1;
            tx_data   <= cmd_mem[rd_ptr];
            tx_is_cmd <= 1'b1;
        end else if (grant_data) begin
            tx_write  <= 1'b1;
            tx_data   <= data_hold;
            tx_is_cmd <= 1'b0;
        end else if (tx_accept) begin
            tx_write  <= 1'b0;
        end
    end

    assign DATA_READY_O   = !data_full;
    assign CMD_READY_O    = !cmd_full;
    assign CMD_LEVEL_O    = cmd_cnt;
    assign CMD_OVERFLOW_O = overflow;
    assign TX_WRITE_O     = tx_write;
    assign TX_DATA_O      = tx_data;
    assign TX_IS_CMD_O    = tx_is_cmd;
    assign BUSY_O         = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (CMD_DEPTH=4, STARVE_LIMIT=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_uart_tx_scheduler;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic       DATA_WRITE_I = 1'b0;
    logic [7:0] DATA_I = 8'h00;
    logic       DATA_READY_O;
    logic       CMD_SEND_I = 1'b0;
    logic [7:0] CMD_I = 8'h00;
    logic       CMD_READY_O;
    logic [2:0] CMD_LEVEL_O;
    logic       CMD_OVERFLOW_O;
    logic       CLR_OVERFLOW_I = 1'b0;
    logic       TX_READY_I = 1'b0;
    logic       TX_WRITE_O;
    logic [7:0] TX_DATA_O;
    logic       TX_IS_CMD_O;
    logic       BUSY_O;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] log_q[$];

    uart_tx_scheduler #(.CMD_DEPTH(4), .STARVE_LIMIT(4)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .DATA_WRITE_I(DATA_WRITE_I), .DATA_I(DATA_I), .DATA_READY_O(DATA_READY_O),
        .CMD_SEND_I(CMD_SEND_I), .CMD_I(CMD_I), .CMD_READY_O(CMD_READY_O),
        .CMD_LEVEL_O(CMD_LEVEL_O), .CMD_OVERFLOW_O(CMD_OVERFLOW_O),
        .CLR_OVERFLOW_I(CLR_OVERFLOW_I), .TX_READY_I(TX_READY_I),
        .TX_WRITE_O(TX_WRITE_O), .TX_DATA_O(TX_DATA_O), .TX_IS_CMD_O(TX_IS_CMD_O),
        .BUSY_O(BUSY_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] b);
        CMD_SEND_I = 1'b1;
        CMD_I      = b;
        tick();
        CMD_SEND_I = 1'b0;
    endtask

    task automatic push_data(input logic [7:0] b);
        DATA_WRITE_I = 1'b1;
        DATA_I       = b;
        tick();
        DATA_WRITE_I = 1'b0;
    endtask

    // Records every byte offered to the UART; TX_READY_I must be high so each offer lasts one sample.
    task automatic collect(input int cycles);
        log_q.delete();
        for (int i = 0; i < cycles; i++) begin
            if (TX_WRITE_O === 1'b1) log_q.push_back({TX_IS_CMD_O, TX_DATA_O});
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_vec++; if (TX_WRITE_O !== 1'b0) begin n_err++; $display("FAIL reset_tx_write got %b exp 0", TX_WRITE_O); end
        n_vec++; if (TX_DATA_O !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h exp 00", TX_DATA_O); end
        n_vec++; if (TX_IS_CMD_O !== 1'b0) begin n_err++; $display("FAIL reset_is_cmd got %b exp 0", TX_IS_CMD_O); end
        n_vec++; if (DATA_READY_O !== 1'b1) begin n_err++; $display("FAIL reset_data_ready got %b exp 1", DATA_READY_O); end
        n_vec++; if (CMD_READY_O !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got %b exp 1", CMD_READY_O); end
        n_vec++; if (CMD_LEVEL_O !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", CMD_LEVEL_O); end
        n_vec++; if (CMD_OVERFLOW_O !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b exp 0", CMD_OVERFLOW_O); end
        n_vec++; if (BUSY_O !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", BUSY_O); end
        RST_I = 1'b0;
        tick();
    endtask

    task automatic test_single_cmd();
        TX_READY_I = 1'b1;
        push_cmd(8'h15);
        n_vec++; if (TX_WRITE_O !== 1'b0) begin n_err++; $display("FAIL single_e0_write got %b exp 0", TX_WRITE_O); end
        n_vec++; if (CMD_LEVEL_O !== 3'd1) begin n_err++; $display("FAIL single_e0_level got %0d exp 1", CMD_LEVEL_O); end
        tick();
        n_vec++; if (TX_WRITE_O !== 1'b1) begin n_err++; $display("FAIL single_write got %b exp 1", TX_WRITE_O); end
        n_vec++; if (TX_DATA_O !== 8'h15) begin n_err++; $display("FAIL single_data got %h exp 15", TX_DATA_O); end
        n_vec++; if (TX_IS_CMD_O !== 1'b1) begin n_err++; $display("FAIL single_is_cmd got %b exp 1", TX_IS_CMD_O); end
        n_vec++; if (CMD_LEVEL_O !== 3'd0) begin n_err++; $display("FAIL single_level got %0d exp 0", CMD_LEVEL_O); end
        tick();
        n_vec++; if (TX_WRITE_O !== 1'b0) begin n_err++; $display("FAIL single_gap_write got %b exp 0", TX_WRITE_O); end
        n_vec++; if (BUSY_O !== 1'b1) begin n_err++; $display("FAIL single_gap_busy got %b exp 1", BUSY_O); end
        tick();
        n_vec++; if (BUSY_O !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got %b exp 0", BUSY_O); end
    endtask

    task automatic test_data_byte();
        TX_READY_I = 1'b1;
        push_data(8'h5A);
        n_vec++; if (DATA_READY_O !== 1'b0) begin n_err++; $display("FAIL data_held_ready got %b exp 0", DATA_READY_O); end
        tick();
        n_vec++; if (TX_WRITE_O !== 1'b1) begin n_err++; $display("FAIL data_write got %b exp 1", TX_WRITE_O); end
        n_vec++; if (TX_DATA_O !== 8'h5A) begin n_err++; $display("FAIL data_byte got %h exp 5a", TX_DATA_O); end
        n_vec++; if (TX_IS_CMD_O !== 1'b0) begin n_err++; $display("FAIL data_is_cmd got %b exp 0", TX_IS_CMD_O); end
        n_vec++; if (DATA_READY_O !== 1'b1) begin n_err++; $display("FAIL data_freed_ready got %b exp 1", DATA_READY_O); end
        tick();
        tick();
        n_vec++; if (BUSY_O !== 1'b0) begin n_err++; $display("FAIL data_idle_busy got %b exp 0", BUSY_O); end
    endtask

    task automatic test_starvation();
        logic [8:0] exp_q[$];
        logic [7:0] late[2];
        int pushed;
        exp_q = '{9'h110, 9'h131, 9'h132, 9'h133, 9'h134, 9'h0A5, 9'h1C5, 9'h1C6};
        late[0] = 8'hC5;
        late[1] = 8'hC6;
        pushed = 0;
        TX_READY_I = 1'b0;
        push_cmd(8'h10);
        push_cmd(8'h31);
        push_cmd(8'h32);
        push_cmd(8'h33);
        push_cmd(8'h34);
        push_data(8'hA5);
        n_vec++; if (CMD_LEVEL_O !== 3'd4) begin n_err++; $display("FAIL starve_level got %0d exp 4", CMD_LEVEL_O); end
        TX_READY_I = 1'b1;
        log_q.delete();
        for (int i = 0; i < 60; i++) begin
            if (TX_WRITE_O === 1'b1) log_q.push_back({TX_IS_CMD_O, TX_DATA_O});
            if (pushed < 2 && CMD_READY_O === 1'b1) begin
                CMD_SEND_I = 1'b1;
                CMD_I      = late[pushed];
                pushed++;
            end else begin
                CMD_SEND_I = 1'b0;
            end
            tick();
        end
        CMD_SEND_I = 1'b0;
        n_vec++; if (log_q.size() != exp_q.size()) begin n_err++; $display("FAIL starve_count got %0d exp %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL starve_order[%0d] got %h exp %h", i, (i < log_q.size()) ? log_q[i] : 9'h000, exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        TX_READY_I = 1'b0;
        push_cmd(8'h77);
        tick();
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (TX_WRITE_O !== 1'b1 || TX_DATA_O !== 8'h77) begin
                n_err++; $display("FAIL stall_hold[%0d] got write=%b data=%h exp write=1 data=77", i, TX_WRITE_O, TX_DATA_O);
            end
            tick();
        end
        TX_READY_I = 1'b1;
        tick();
        n_vec++; if (TX_WRITE_O !== 1'b0) begin n_err++; $display("FAIL stall_release_write got %b exp 0", TX_WRITE_O); end
        n_vec++; if (BUSY_O !== 1'b1) begin n_err++; $display("FAIL stall_gap_busy got %b exp 1", BUSY_O); end
        tick();
        n_vec++; if (BUSY_O !== 1'b0) begin n_err++; $display("FAIL stall_idle_busy got %b exp 0", BUSY_O); end
    endtask

    task automatic test_overflow();
        logic [8:0] exp_q[$];
        exp_q = '{9'h120, 9'h141, 9'h142, 9'h143, 9'h144};
        TX_READY_I = 1'b0;
        push_cmd(8'h20);
        push_cmd(8'h41);
        push_cmd(8'h42);
        push_cmd(8'h43);
        push_cmd(8'h44);
        push_cmd(8'h45);
        n_vec++; if (CMD_LEVEL_O !== 3'd4) begin n_err++; $display("FAIL ovf_level got %0d exp 4", CMD_LEVEL_O); end
        n_vec++; if (CMD_READY_O !== 1'b0) begin n_err++; $display("FAIL ovf_ready got %b exp 0", CMD_READY_O); end
        n_vec++; if (CMD_OVERFLOW_O !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", CMD_OVERFLOW_O); end
        CLR_OVERFLOW_I = 1'b1;
        push_cmd(8'h46);
        CLR_OVERFLOW_I = 1'b0;
        n_vec++; if (CMD_OVERFLOW_O !== 1'b1) begin n_err++; $display("FAIL ovf_set_beats_clear got %b exp 1", CMD_OVERFLOW_O); end
        CLR_OVERFLOW_I = 1'b1;
        tick();
        CLR_OVERFLOW_I = 1'b0;
        n_vec++; if (CMD_OVERFLOW_O !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", CMD_OVERFLOW_O); end
        TX_READY_I = 1'b1;
        collect(30);
        n_vec++; if (log_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_tx_count got %0d exp %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL ovf_order[%0d] got %h exp %h", i, (i < log_q.size()) ? log_q[i] : 9'h000, exp_q[i]);
            end
        end
    endtask

    task automatic test_push_pop();
        logic [8:0] exp_q[$];
        int guard;
        exp_q = '{9'h152, 9'h153, 9'h154, 9'h155};
        TX_READY_I = 1'b0;
        push_cmd(8'h50);
        push_cmd(8'h51);
        push_cmd(8'h52);
        TX_READY_I = 1'b1;
        guard = 0;
        while (BUSY_O !== 1'b0 && guard < 10) begin tick(); guard++; end
        n_vec++; if (BUSY_O !== 1'b0) begin n_err++; $display("FAIL pp_idle_timeout got busy=%b exp 0", BUSY_O); end
        push_cmd(8'h53);
        n_vec++; if (CMD_LEVEL_O !== 3'd2) begin n_err++; $display("FAIL pp_level_same got %0d exp 2", CMD_LEVEL_O); end
        n_vec++; if (TX_DATA_O !== 8'h51) begin n_err++; $display("FAIL pp_popped got %h exp 51", TX_DATA_O); end
        TX_READY_I = 1'b0;
        push_cmd(8'h54);
        push_cmd(8'h55);
        n_vec++; if (CMD_LEVEL_O !== 3'd4) begin n_err++; $display("FAIL pp_full_level got %0d exp 4", CMD_LEVEL_O); end
        TX_READY_I = 1'b1;
        guard = 0;
        while (BUSY_O !== 1'b0 && guard < 10) begin tick(); guard++; end
        n_vec++; if (BUSY_O !== 1'b0) begin n_err++; $display("FAIL pp_idle2_timeout got busy=%b exp 0", BUSY_O); end
        push_cmd(8'hEE);
        n_vec++; if (CMD_LEVEL_O !== 3'd3) begin n_err++; $display("FAIL pp_full_pop_level got %0d exp 3", CMD_LEVEL_O); end
        n_vec++; if (CMD_OVERFLOW_O !== 1'b1) begin n_err++; $display("FAIL pp_full_pop_ovf got %b exp 1", CMD_OVERFLOW_O); end
        collect(30);
        n_vec++; if (log_q.size() != exp_q.size()) begin n_err++; $display("FAIL pp_tx_count got %0d exp %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL pp_order[%0d] got %h exp %h", i, (i < log_q.size()) ? log_q[i] : 9'h000, exp_q[i]);
            end
        end
        CLR_OVERFLOW_I = 1'b1;
        tick();
        CLR_OVERFLOW_I = 1'b0;
    endtask

    task automatic test_reset_mid_send();
        int writes;
        TX_READY_I = 1'b0;
        push_cmd(8'h60);
        push_cmd(8'h61);
        push_cmd(8'h62);
        push_cmd(8'h63);
        n_vec++; if (TX_WRITE_O !== 1'b1 || CMD_LEVEL_O !== 3'd3) begin
            n_err++; $display("FAIL rst_setup got write=%b level=%0d exp write=1 level=3", TX_WRITE_O, CMD_LEVEL_O);
        end
        #2;
        RST_I = 1'b1;
        #1;
        n_vec++; if (TX_WRITE_O !== 1'b0) begin n_err++; $display("FAIL rst_async_write got %b exp 0", TX_WRITE_O); end
        n_vec++; if (TX_DATA_O !== 8'h00) begin n_err++; $display("FAIL rst_async_data got %h exp 00", TX_DATA_O); end
        n_vec++; if (TX_IS_CMD_O !== 1'b0) begin n_err++; $display("FAIL rst_async_is_cmd got %b exp 0", TX_IS_CMD_O); end
        n_vec++; if (CMD_LEVEL_O !== 3'd0) begin n_err++; $display("FAIL rst_async_level got %0d exp 0", CMD_LEVEL_O); end
        n_vec++; if (BUSY_O !== 1'b0) begin n_err++; $display("FAIL rst_async_busy got %b exp 0", BUSY_O); end
        #1;
        RST_I = 1'b0;
        TX_READY_I = 1'b1;
        writes = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (TX_WRITE_O !== 1'b0) writes++;
        end
        n_vec++; if (writes != 0) begin n_err++; $display("FAIL rst_no_tx_after got %0d writes exp 0", writes); end
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_data_byte();
        test_starvation();
        test_stall();
        test_overflow();
        test_push_pop();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
